// File: rtl/alu_sched_pkg.sv
// Shared constants, FSM encodings and helpers for the round-robin ALU scheduler.
package alu_sched_pkg;

   localparam int N_REQ = 4;
   localparam int PTR_W = 2;
   localparam int TMR_W = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   function automatic logic [N_REQ-1:0] id2oh(input logic [PTR_W-1:0] id);
      id2oh = {{(N_REQ-1){1'b0}}, 1'b1} << id;
   endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// Combinational rotating-priority picker: the first set request at or after ptr wins.
module rr_arbiter_4
   import alu_sched_pkg::*;
(
   input  logic [N_REQ-1:0] i_req,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [N_REQ-1:0] o_gnt,
   output logic [PTR_W-1:0] o_gnt_id,
   output logic             o_any
);

   logic [PTR_W-1:0] w_idx;

   // scan from the farthest slot down so the slot nearest ptr is written last and wins
   always_comb begin
      o_gnt_id = i_ptr;
      o_any    = 1'b0;
      w_idx    = i_ptr;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         w_idx    = i_ptr + PTR_W'(k);
         o_any    = o_any | i_req[w_idx];
         o_gnt_id = i_req[w_idx] ? w_idx : o_gnt_id;
      end
      o_gnt = o_any ? id2oh(o_gnt_id) : {N_REQ{1'b0}};
   end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one ALU among four requesters.
// Optional per-requester completion counters are enabled with ALU_SCHED_STATS_EN.
module alu_rr_scheduler
   import alu_sched_pkg::*;
#(
   parameter int W       = 8,
   parameter int OPW     = 3,
   parameter int TIMEOUT = 15
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [N_REQ-1:0]     i_req_valid,
   output logic [N_REQ-1:0]     o_req_ready,
   input  logic [N_REQ*OPW-1:0] i_req_op,
   input  logic [N_REQ*W-1:0]   i_req_a,
   input  logic [N_REQ*W-1:0]   i_req_b,
   output logic [OPW-1:0]       o_alu_op,
   output logic [W-1:0]         o_alu_a,
   output logic [W-1:0]         o_alu_b,
   output logic                 o_alu_start,
   input  logic                 i_alu_done,
   input  logic [W-1:0]         i_alu_result,
   output logic [N_REQ-1:0]     o_resp_valid,
   output logic [W-1:0]         o_resp_data,
   output logic                 o_resp_err,
   output logic                 o_busy,
   output logic [PTR_W-1:0]     o_grant_id
`ifdef ALU_SCHED_STATS_EN
   ,
   output logic [31:0]          o_stat_cnt
`endif
);

   logic [1:0]       r_state;
   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W-1:0] r_gid;
   logic [TMR_W-1:0] r_tmr;
   logic [OPW-1:0]   r_op;
   logic [W-1:0]     r_a;
   logic [W-1:0]     r_b;
   logic             r_alu_start;
   logic [N_REQ-1:0] r_resp_valid;
   logic [W-1:0]     r_resp_data;
   logic             r_resp_err;
   logic             r_busy;

   logic [1:0]       w_state_nxt;
   logic             w_accept;
   logic             w_done_ok;
   logic             w_tmo;
   logic [N_REQ-1:0] w_gnt;
   logic [PTR_W-1:0] w_gnt_id;
   logic             w_any;

   rr_arbiter_4 u_arb (
      .i_req    (i_req_valid),
      .i_ptr    (r_ptr),
      .o_gnt    (w_gnt),
      .o_gnt_id (w_gnt_id),
      .o_any    (w_any)
   );

   // next-state decode; done is tested before the timer so it wins a tie
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_done_ok   = 1'b0;
      w_tmo       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_state_nxt = ST_ISSUE;
               w_accept    = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ISSUE: w_state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (i_alu_done) begin
               w_state_nxt = ST_RESP;
               w_done_ok   = 1'b1;
            end else if (r_tmr == TMR_W'(TIMEOUT - 1)) begin
               w_state_nxt = ST_RESP;
               w_tmo       = 1'b1;
            end else begin
               w_state_nxt = ST_WAIT;
            end
         end
         ST_RESP: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM state, latched request, ALU drive and response registers
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_ptr        <= '0;
         r_gid        <= '0;
         r_tmr        <= '0;
         r_op         <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_alu_start  <= 1'b0;
         r_resp_valid <= '0;
         r_resp_data  <= '0;
         r_resp_err   <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_busy       <= (w_state_nxt != ST_IDLE);
         r_alu_start  <= w_accept;
         r_resp_valid <= '0;
         if (w_accept) begin
            r_gid <= w_gnt_id;
            r_op  <= i_req_op[w_gnt_id*OPW +: OPW];
            r_a   <= i_req_a[w_gnt_id*W +: W];
            r_b   <= i_req_b[w_gnt_id*W +: W];
         end
         if (r_state == ST_ISSUE) begin
            r_tmr <= '0;
         end else if (r_state == ST_WAIT) begin
            r_tmr <= r_tmr + 8'd1;
         end
         if (w_done_ok) begin
            r_resp_data  <= i_alu_result;
            r_resp_err   <= 1'b0;
            r_resp_valid <= id2oh(r_gid);
         end else if (w_tmo) begin
            r_resp_data  <= '0;
            r_resp_err   <= 1'b1;
            r_resp_valid <= id2oh(r_gid);
         end
         if (r_state == ST_RESP) begin
            r_ptr <= r_gid + 2'd1;
         end
      end
   end

   // the accept pulse is the only combinational output so transfer happens in the same cycle
   assign o_req_ready  = (r_state == ST_IDLE && i_rst_n) ? w_gnt : {N_REQ{1'b0}};
   assign o_alu_op     = r_op;
   assign o_alu_a      = r_a;
   assign o_alu_b      = r_b;
   assign o_alu_start  = r_alu_start;
   assign o_resp_valid = r_resp_valid;
   assign o_resp_data  = r_resp_data;
   assign o_resp_err   = r_resp_err;
   assign o_busy       = r_busy;
   assign o_grant_id   = r_gid;

`ifdef ALU_SCHED_STATS_EN
   logic [7:0] r_stat [N_REQ];

   // saturating completion counters; timeouts do not count
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < N_REQ; i++) begin
            r_stat[i] <= 8'd0;
         end
      end else if (w_done_ok && r_stat[r_gid] != 8'hFF) begin
         r_stat[r_gid] <= r_stat[r_gid] + 8'd1;
      end
   end

   assign o_stat_cnt = {r_stat[3], r_stat[2], r_stat[1], r_stat[0]};
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Randomized self-checking bench for alu_rr_scheduler against a transaction-level model.
module tb_alu_rr_scheduler;

   localparam int TMO = 15;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [11:0] req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [2:0]  alu_op;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic        alu_start;
   logic        alu_done;
   logic [7:0]  alu_result;
   logic [3:0]  resp_valid;
   logic [7:0]  resp_data;
   logic        resp_err;
   logic        busy;
   logic [1:0]  grant_id;
`ifdef ALU_SCHED_STATS_EN
   logic [31:0] stat_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;
   int ptr_m = 0;
   int cnt_m [4];

   alu_rr_scheduler #(.W(8), .OPW(3), .TIMEOUT(TMO)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_op     (req_op),
      .i_req_a      (req_a),
      .i_req_b      (req_b),
      .o_alu_op     (alu_op),
      .o_alu_a      (alu_a),
      .o_alu_b      (alu_b),
      .o_alu_start  (alu_start),
      .i_alu_done   (alu_done),
      .i_alu_result (alu_result),
      .o_resp_valid (resp_valid),
      .o_resp_data  (resp_data),
      .o_resp_err   (resp_err),
      .o_busy       (busy),
      .o_grant_id   (grant_id)
`ifdef ALU_SCHED_STATS_EN
      ,
      .o_stat_cnt   (stat_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // round-robin rule: first valid requester scanning ptr, ptr+1, ... mod 4
   function automatic int pick(input logic [3:0] v, input int p);
      for (int k = 0; k < 4; k++) begin
         if (v[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   task automatic check_stats();
`ifdef ALU_SCHED_STATS_EN
      chk("stat_cnt", stat_cnt, {8'(cnt_m[3]), 8'(cnt_m[2]), 8'(cnt_m[1]), 8'(cnt_m[0])});
`endif
   endtask

   task automatic reset_check();
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_alu_start", 32'(alu_start), 32'd0);
      chk("rst_alu_op", 32'(alu_op), 32'd0);
      chk("rst_alu_a", 32'(alu_a), 32'd0);
      chk("rst_alu_b", 32'(alu_b), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_data", 32'(resp_data), 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      check_stats();
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = 4'd0;
      alu_done = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      ptr_m = 0;
      for (int i = 0; i < 4; i++) cnt_m[i] = 0;
      reset_check();
   endtask

   // one full transaction; d = cycles from start to alu_done (outside 1..TMO means never)
   task automatic do_op(input logic [3:0] v, input logic [11:0] ops, input logic [31:0] as,
                        input logic [31:0] bs, input int d, input logic [7:0] res);
      int w;
      int ew;
      int rc;
      logic eerr;
      logic [3:0] oh;
      w  = pick(v, ptr_m);
      oh = 4'(1 << w);
      ew   = (d >= 1 && d <= TMO) ? d : TMO;
      eerr = !(d >= 1 && d <= TMO);
      @(negedge clk);
      req_valid = v; req_op = ops; req_a = as; req_b = bs;
      alu_done = 1'($urandom); alu_result = 8'($urandom);
      #1;
      chk("req_ready", 32'(req_ready), 32'(oh));
      chk("busy_idle", 32'(busy), 32'd0);
      @(negedge clk);
      req_valid = 4'($urandom); req_op = 12'($urandom); req_a = $urandom; req_b = $urandom;
      alu_done = 1'($urandom);
      #1;
      chk("alu_start", 32'(alu_start), 32'd1);
      chk("grant_id", 32'(grant_id), 32'(w));
      chk("alu_op", 32'(alu_op), 32'(ops[w*3 +: 3]));
      chk("alu_a", 32'(alu_a), 32'(as[w*8 +: 8]));
      chk("alu_b", 32'(alu_b), 32'(bs[w*8 +: 8]));
      chk("ready_busy", 32'(req_ready), 32'd0);
      rc = -1;
      for (int c = 2; c <= TMO + 4 && rc < 0; c++) begin
         @(negedge clk);
         req_valid  = 4'($urandom);
         alu_done   = (c == 1 + d);
         alu_result = (c == 1 + d) ? res : 8'($urandom);
         #1;
         if (resp_valid != 4'd0) begin
            rc = c;
         end else begin
            chk("alu_start_low", 32'(alu_start), 32'd0);
            chk("alu_a_hold", 32'(alu_a), 32'(as[w*8 +: 8]));
         end
      end
      alu_done  = 1'b0;
      req_valid = 4'd0;
      chk("resp_cycle", rc, 2 + ew);
      chk("resp_valid", 32'(resp_valid), 32'(oh));
      chk("resp_data", 32'(resp_data), 32'(eerr ? 8'd0 : res));
      chk("resp_err", 32'(resp_err), 32'(eerr));
      chk("busy_resp", 32'(busy), 32'd1);
      if (!eerr && cnt_m[w] != 255) cnt_m[w]++;
      ptr_m = (w + 1) % 4;
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 4'd0; req_op = 12'd0; req_a = 32'd0; req_b = 32'd0;
      alu_done = 1'b0; alu_result = 8'd0;
      repeat (2) @(posedge clk);
      apply_reset();

      // single request from requester 2
      do_op(4'b0100, 12'(3 << 6), 32'h0012_0000, 32'h0034_0000, 2, 8'h46);

      // all requesting: order continues from ptr
      for (int i = 0; i < 8; i++)
         do_op(4'b1111, 12'($urandom), $urandom, $urandom, 1 + (i % 3), 8'($urandom));

      // wrap 3 -> 0
      do_op(4'b0100, 12'($urandom), $urandom, $urandom, 1, 8'($urandom));
      do_op(4'b1001, 12'($urandom), $urandom, $urandom, 1, 8'($urandom));
      do_op(4'b1001, 12'($urandom), $urandom, $urandom, 1, 8'($urandom));

      // timeout, done on the last WAIT cycle, then normal service
      do_op(4'b0010, 12'($urandom), $urandom, $urandom, 255, 8'hAA);
      do_op(4'b0010, 12'($urandom), $urandom, $urandom, TMO, 8'h5C);
      do_op(4'b0010, 12'($urandom), $urandom, $urandom, TMO + 1, 8'h77);
      do_op(4'b1000, 12'($urandom), $urandom, $urandom, 3, 8'h19);

      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            req_valid = 4'd0;
            #1;
            chk("idle_ready", 32'(req_ready), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
         end
         do_op(4'($urandom_range(1, 15)), 12'($urandom), $urandom, $urandom,
               $urandom_range(1, TMO + 3), 8'($urandom));
      end
      check_stats();

      // reset while waiting on the ALU
      @(negedge clk);
      req_valid = 4'b0001; req_a = $urandom;
      @(negedge clk);
      req_valid = 4'd0;
      repeat (3) @(negedge clk);
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         alu_done = 1'b1; alu_result = 8'hEE;
         #1;
         chk("late_done_resp", 32'(resp_valid), 32'd0);
         chk("late_done_busy", 32'(busy), 32'd0);
      end
      alu_done = 1'b0;
      do_op(4'b0101, 12'($urandom), $urandom, $urandom, 2, 8'h3C);

`ifdef ALU_SCHED_STATS_EN
      apply_reset();
      for (int i = 0; i < 300; i++)
         do_op(4'b0010, 12'($urandom), $urandom, $urandom, 1, 8'($urandom));
      check_stats();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
